// File: rtl/nn_pkg.sv
// Shared types for the NN matrix datapath.
// - WORD_W          : default element width
// - word_t          : one matrix element
// - loader_state_e  : matrix_stream_loader FSM states
package nn_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {LDR_IDLE, LDR_LOAD, LDR_FULL} loader_state_e;
endpackage

// File: rtl/mat_index_counter.sv
// Row/col position counter for a ROWS x COLS matrix walked in either arrival order.
// COL_FIRST=0: col is the fast (inner) index, i.e. row-major arrival.
// COL_FIRST=1: row is the fast (inner) index, i.e. column-major arrival.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   clear         - synchronous return to (0,0)
//   advance       - step to the next position, wrapping at the matrix end
//   row, col      - current position
//   flat_idx      - row-major storage slot row*COLS+col
//   at_last       - current position is the final arrival
module mat_index_counter #(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter bit COL_FIRST = 1'b0,
  localparam int N  = ROWS * COLS,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [FW-1:0] flat_idx,
  output logic          at_last
);

  logic row_end, col_end;
  assign row_end = (row == RW'(ROWS - 1));
  assign col_end = (col == CW'(COLS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (!COL_FIRST) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
      end else begin
        row <= row_end ? '0 : row + 1'b1;
        if (row_end) col <= col_end ? '0 : col + 1'b1;
      end
    end
  end

  // Constant multiply only; storage is always row-major regardless of arrival order.
  assign flat_idx = FW'(row) * FW'(COLS) + FW'(col);
  assign at_last  = row_end && col_end;

endmodule

// File: rtl/matrix_stream_loader.sv
// Deserialises a valid/ready element stream into a row-major matrix held
// stable for the matrix dot-product stage, then pulses compute_enable.
// Build option: define MATRIX_STREAM_LOADER_TRANSPOSE_EN for column-major
// arrival (B operand); default is row-major arrival. Output is row-major in both.
// Ports:
//   clk, reset_n    - clock, async active-low reset
//   start           - begin a load (honoured in IDLE, or in FULL with consume)
//   in_valid/in_ready/in_data/in_last - element stream, ready only in LOAD
//   matrix_out      - ROWS*COLS elements, (r,c) at r*COLS+c
//   matrix_valid    - matrix complete and held (FULL)
//   compute_enable  - one-cycle pulse on entry to FULL
//   consume         - downstream done with the matrix
//   busy            - not IDLE
//   error           - sticky framing error, cleared by an accepted start
module matrix_stream_loader
  import nn_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] matrix_out [ROWS*COLS],
  output logic             matrix_valid,
  output logic             compute_enable,
  input  logic             consume,
  output logic             busy,
  output logic             error
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW = (N > 1) ? $clog2(N) : 1;

`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
  localparam bit COL_FIRST = 1'b1;
`else
  localparam bit COL_FIRST = 1'b0;
`endif

  loader_state_e state, next_state;

  logic          beat, accept_start, at_last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [FW-1:0] flat_idx;

  assign beat         = in_valid && in_ready;
  // Starts honoured from IDLE, or from FULL when the held matrix is released.
  assign accept_start = start && ((state == LDR_IDLE) ||
                                  (state == LDR_FULL && consume));

  mat_index_counter #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .COL_FIRST (COL_FIRST)
  ) u_idx (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept_start),
    .advance  (beat),
    .row      (row),
    .col      (col),
    .flat_idx (flat_idx),
    .at_last  (at_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LDR_IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      LDR_IDLE: if (start) next_state = LDR_LOAD;
      LDR_LOAD: begin
        if (beat) begin
          if (at_last)      next_state = LDR_FULL;
          else if (in_last) next_state = LDR_IDLE;
        end
      end
      LDR_FULL: if (consume) next_state = start ? LDR_LOAD : LDR_IDLE;
      default:  next_state = LDR_IDLE;
    endcase
  end

  // Moore outputs decoded from the state flop
  always_comb begin
    in_ready     = 1'b0;
    matrix_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      LDR_LOAD: begin in_ready = 1'b1;     busy = 1'b1; end
      LDR_FULL: begin matrix_valid = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Pulse flop: set only on the LOAD->FULL transition, so it covers the first FULL cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) compute_enable <= 1'b0;
    else          compute_enable <= (state == LDR_LOAD) && (next_state == LDR_FULL);
  end

  // Framing error: in_last must coincide exactly with the final arrival.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        error <= 1'b0;
    else if (accept_start)               error <= 1'b0;
    else if (beat && (at_last != in_last)) error <= 1'b1;
  end

  // Storage: only LOAD beats write, so FULL holds the matrix frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) matrix_out[i] <= '0;
    end else if (beat) begin
      matrix_out[flat_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, in_valid, in_last, consume;
  logic [31:0] in_data;
  logic        in_ready, matrix_valid, compute_enable, busy, error;
  logic [31:0] matrix_out [4];
  logic [31:0] exp_m [4];
  logic [31:0] held0;
  int          n_chk = 0;
  int          n_fail = 0;

  matrix_stream_loader #(.ROWS(2), .COLS(2), .WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .matrix_out     (matrix_out),
    .matrix_valid   (matrix_valid),
    .compute_enable (compute_enable),
    .consume        (consume),
    .busy           (busy),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 0; in_valid = 0; in_last = 0; consume = 0; in_data = '0;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
    exp_m[0] = 1; exp_m[1] = 3; exp_m[2] = 2; exp_m[3] = 4;
`else
    exp_m[0] = 1; exp_m[1] = 2; exp_m[2] = 3; exp_m[3] = 4;
`endif
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mvalid", {31'b0, matrix_valid}, 0);
    chk("rst_ce", {31'b0, compute_enable}, 0);
    chk("rst_error", {31'b0, error}, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_out%0d", i), matrix_out[i], 0);
    reset_n = 1'b1;
    tick();

    // IDLE ignores in_valid
    in_valid = 1'b1; in_data = 32'hdead;
    tick();
    in_valid = 1'b0;
    chk("idle_busy", {31'b0, busy}, 0);

    // Basic load
    do_start();
    chk("load_in_ready", {31'b0, in_ready}, 1);
    chk("load_busy", {31'b0, busy}, 1);
    beat(1, 0); beat(2, 0); beat(3, 0);
    chk("load_ce_early", {31'b0, compute_enable}, 0);
    beat(4, 1);
    chk("basic_mvalid", {31'b0, matrix_valid}, 1);
    chk("basic_ce", {31'b0, compute_enable}, 1);
    chk("basic_error", {31'b0, error}, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_out%0d", i), matrix_out[i], exp_m[i]);
    tick();
    chk("basic_ce_pulse", {31'b0, compute_enable}, 0);
    chk("basic_mvalid_hold", {31'b0, matrix_valid}, 1);

    // Backpressure and hold in FULL; lone start ignored
    held0 = matrix_out[0];
    in_valid = 1'b1; in_data = 9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_in_ready", {31'b0, in_ready}, 0);
    chk("full_mvalid", {31'b0, matrix_valid}, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("hold_out%0d", i), matrix_out[i], exp_m[i]);
    chk("hold_out0_same", matrix_out[0], held0);

    // consume + start -> LOAD directly
    consume = 1'b1; start = 1'b1;
    tick();
    consume = 1'b0; start = 1'b0;
    chk("cs_in_ready", {31'b0, in_ready}, 1);
    chk("cs_mvalid", {31'b0, matrix_valid}, 0);
    chk("cs_busy", {31'b0, busy}, 1);

    // Missing last: FULL entered with error
    beat(5, 0); beat(6, 0); beat(7, 0); beat(8, 0);
    chk("miss_mvalid", {31'b0, matrix_valid}, 1);
    chk("miss_ce", {31'b0, compute_enable}, 1);
    chk("miss_error", {31'b0, error}, 1);
    chk("miss_out3", matrix_out[3], 8);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("cons_mvalid", {31'b0, matrix_valid}, 0);
    chk("cons_busy", {31'b0, busy}, 0);
    chk("cons_error_sticky", {31'b0, error}, 1);
    do_start();
    chk("start_clears_err", {31'b0, error}, 0);

    // Early last on beat 2
    beat(10, 0);
    beat(11, 1);
    chk("early_error", {31'b0, error}, 1);
    chk("early_busy", {31'b0, busy}, 0);
    chk("early_mvalid", {31'b0, matrix_valid}, 0);
    chk("early_ce", {31'b0, compute_enable}, 0);
    chk("early_out0", matrix_out[0], 10);
    tick();
    chk("early_ce_later", {31'b0, compute_enable}, 0);

    // Reset mid-load
    do_start();
    beat(20, 0); beat(21, 0);
    chk("mid_busy_pre", {31'b0, busy}, 1);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_out%0d", i), matrix_out[i], 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 0);
    chk("mid_rst_error", {31'b0, error}, 0);
    #3;
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
